// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: fetch-stage state encodings and the NOP used to scrub the IF/ID payload
package ifetch_unit_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;
  localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/ifetch_skid.sv
// ifetch_skid: one-entry holding register for an acked fetch that decode could not take yet
module ifetch_skid (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [63:0] i_data,
  output logic        o_valid,
  output logic [63:0] o_data
);
  logic        r_valid;
  logic [63:0] r_data;
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage driving the PC enable, the instruction memory port
// and the registered IF/ID payload, with a one-entry skid for decode back-pressure
module ifetch_unit
  import ifetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_pc_addr,
  output logic        o_pc_hold,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_id_stall,
  input  logic        i_flush,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc
);
  state_t      r_state, w_next;
  logic        r_if_valid;
  logic [31:0] r_if_instr, r_if_pc, r_drain_addr;
  logic        w_req, w_hold, w_slot_free;
  logic [31:0] w_addr;
  logic        w_out_load, w_out_clear, w_skid_load, w_skid_unload, w_drain_load;
  logic        w_skid_valid;
  logic [63:0] w_skid_data, w_out_data;

  assign w_slot_free = !r_if_valid || !i_id_stall;
  assign w_out_data  = (r_state == S_FULL) ? w_skid_data : {i_imem_rdata, i_pc_addr};

  always_comb begin
    w_next        = r_state;
    w_req         = 1'b0;
    w_addr        = i_pc_addr;
    w_hold        = 1'b1;
    w_out_load    = 1'b0;
    w_out_clear   = 1'b0;
    w_skid_load   = 1'b0;
    w_skid_unload = 1'b0;
    w_drain_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next      = S_FETCH;
        w_out_clear = r_if_valid && !i_id_stall;
      end
      S_FETCH: begin
        w_req  = 1'b1;
        w_hold = !i_imem_ack;
        if (i_flush) begin
          w_drain_load = !i_imem_ack;
          w_next       = i_imem_ack ? S_FETCH : S_DRAIN;
        end else if (i_imem_ack) begin
          w_out_load  = w_slot_free;
          w_skid_load = !w_slot_free;
          w_next      = w_slot_free ? S_FETCH : S_FULL;
        end else begin
          w_out_clear = r_if_valid && !i_id_stall;
        end
      end
      S_FULL: begin
        w_skid_unload = !i_flush && !i_id_stall && w_skid_valid;
        w_out_load    = w_skid_unload;
        w_next        = (i_flush || !i_id_stall) ? S_FETCH : S_FULL;
      end
      S_DRAIN: begin
        w_req  = 1'b1;
        w_addr = r_drain_addr;
        w_next = i_imem_ack ? S_FETCH : S_DRAIN;
      end
      default: w_next = S_IDLE;
    endcase
    // a redirect always lets the PC take the branch target
    w_hold = w_hold && !i_flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_if_valid   <= 1'b0;
      r_if_instr   <= NOP;
      r_if_pc      <= '0;
      r_drain_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_drain_load) r_drain_addr <= i_pc_addr;
      if (i_flush) begin
        r_if_valid <= 1'b0;
        r_if_instr <= NOP;
      end else if (w_out_load) begin
        r_if_valid            <= 1'b1;
        {r_if_instr, r_if_pc} <= w_out_data;
      end else if (w_out_clear) begin
        r_if_valid <= 1'b0;
      end
    end
  end

  ifetch_skid u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_unload(w_skid_unload),
    .i_clear (i_flush),
    .i_data  ({i_imem_rdata, i_pc_addr}),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  assign o_imem_req  = w_req && !reset;
  assign o_imem_addr = w_addr;
  assign o_pc_hold   = w_hold || reset;
  assign o_if_valid  = r_if_valid;
  assign o_if_instr  = r_if_instr;
  assign o_if_pc     = r_if_pc;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scenarios for the fetch stage against a PC register and a
// memory whose word at address A is A ^ 32'hA5A5_0000
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        reset, ack, stall, flush;
  logic [31:0] r_pc, tgt, rdata;
  logic        pc_hold, imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign rdata = imem_addr ^ 32'hA5A5_0000;

  always_ff @(posedge clk) begin
    if (reset) r_pc <= '0;
    else if (!pc_hold) r_pc <= flush ? tgt : r_pc + 32'd4;
  end

  ifetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .i_pc_addr   (r_pc),
    .o_pc_hold   (pc_hold),
    .o_imem_req  (imem_req),
    .o_imem_addr (imem_addr),
    .i_imem_ack  (ack),
    .i_imem_rdata(rdata),
    .i_id_stall  (stall),
    .i_flush     (flush),
    .o_if_valid  (if_valid),
    .o_if_instr  (if_instr),
    .o_if_pc     (if_pc)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; ack = 1'b1; stall = 1'b0; flush = 1'b0; tgt = '0;
    repeat (3) tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=00000000", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=00000000", if_pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL rst_hold got=%b exp=1", pc_hold); end
  endtask

  task automatic test_zero_wait;
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_idle_req got=%b exp=0", imem_req); end
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL zw_idle_hold got=%b exp=1", pc_hold); end
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL zw_idle_ack_ignored got=%b exp=0", if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL zw_req got=%b/%h exp=1/00000000", imem_req, imem_addr); end
    checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL zw_hold got=%b exp=0", pc_hold); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i)) begin errors++; $display("FAIL zw_pc%0d got=%b/%h exp=1/%h", i, if_valid, if_pc, 32'(4 * i)); end
      checks++; if (if_instr !== (32'hA5A5_0000 | 32'(4 * i))) begin errors++; $display("FAIL zw_instr%0d got=%h exp=%h", i, if_instr, 32'hA5A5_0000 | 32'(4 * i)); end
    end
    ack = 1'b0;
  endtask

  task automatic test_delayed_ack;
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL da_consumed got=%b exp=0", if_valid); end
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL da_addr_c got=%h exp=0000000c", imem_addr); end
    ack = 1'b1;
    tick();
    checks++; if (if_pc !== 32'hC) begin errors++; $display("FAIL da_pc_c got=%h exp=0000000c", if_pc); end
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || pc_hold !== 1'b1) begin errors++; $display("FAIL da_wait%0d got=%b/%h/%b exp=1/00000010/1", i, imem_req, imem_addr, pc_hold); end
      tick();
    end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL da_wait_valid got=%b exp=0", if_valid); end
    ack = 1'b1;
    #1;
    checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL da_ack_hold got=%b exp=0", pc_hold); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== 32'hA5A5_0010) begin errors++; $display("FAIL da_out got=%b/%h/%h exp=1/00000010/a5a50010", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_stall_full;
    repeat (3) tick();
    checks++; if (if_pc !== 32'h1C) begin errors++; $display("FAIL sf_pre_pc got=%h exp=0000001c", if_pc); end
    stall = 1'b1;
    #1;
    checks++; if (pc_hold !== 1'b0 || imem_addr !== 32'h20) begin errors++; $display("FAIL sf_skid_cap got=%b/%h exp=0/00000020", pc_hold, imem_addr); end
    tick();
    ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (imem_req !== 1'b0 || pc_hold !== 1'b1) begin errors++; $display("FAIL sf_full%0d got=%b/%b exp=0/1", i, imem_req, pc_hold); end
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h1C) begin errors++; $display("FAIL sf_held%0d got=%b/%h exp=1/0000001c", i, if_valid, if_pc); end
      tick();
    end
    stall = 1'b0;
    #1;
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL sf_unload_hold got=%b exp=1", pc_hold); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h20 || if_instr !== 32'hA5A5_0020) begin errors++; $display("FAIL sf_unload got=%b/%h/%h exp=1/00000020/a5a50020", if_valid, if_pc, if_instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin errors++; $display("FAIL sf_refetch got=%b/%h exp=1/00000024", imem_req, imem_addr); end
  endtask

  task automatic test_flush_drain;
    ack = 1'b1;
    repeat (3) tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h2C) begin errors++; $display("FAIL fd_pre got=%b/%h exp=1/0000002c", if_valid, if_pc); end
    ack = 1'b0; flush = 1'b1; tgt = 32'h100;
    #1;
    checks++; if (imem_addr !== 32'h30 || pc_hold !== 1'b0) begin errors++; $display("FAIL fd_flush got=%h/%b exp=00000030/0", imem_addr, pc_hold); end
    tick();
    flush = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fd_valid_clr got=%b exp=0", if_valid); end
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h30 || pc_hold !== 1'b1) begin errors++; $display("FAIL fd_drain%0d got=%b/%h/%b exp=1/00000030/1", i, imem_req, imem_addr, pc_hold); end
      tick();
    end
    ack = 1'b1;
    #1;
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL fd_ack_hold got=%b exp=1", pc_hold); end
    tick();
    ack = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fd_dropped got=%b exp=0", if_valid); end
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL fd_target got=%b/%h exp=1/00000100", imem_req, imem_addr); end
  endtask

  task automatic test_flush_ack;
    ack = 1'b1;
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin errors++; $display("FAIL fa_pre got=%b/%h exp=1/00000100", if_valid, if_pc); end
    flush = 1'b1; tgt = 32'h200;
    #1;
    checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL fa_hold got=%b exp=0", pc_hold); end
    tick();
    flush = 1'b0; ack = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fa_dropped got=%b exp=0", if_valid); end
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || pc_hold !== 1'b1) begin errors++; $display("FAIL fa_target got=%b/%h/%b exp=1/00000200/1", imem_req, imem_addr, pc_hold); end
  endtask

  task automatic test_reset_full;
    ack = 1'b1;
    tick();
    checks++; if (if_pc !== 32'h200) begin errors++; $display("FAIL rf_pre got=%h exp=00000200", if_pc); end
    stall = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0 || pc_hold !== 1'b1) begin errors++; $display("FAIL rf_full got=%b/%b exp=0/1", imem_req, pc_hold); end
    reset = 1'b1;
    tick();
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || pc_hold !== 1'b1) begin errors++; $display("FAIL rf_reset got=%b/%b/%b exp=0/0/1", if_valid, imem_req, pc_hold); end
    tick();
    reset = 1'b0; stall = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rf_idle_req got=%b exp=0", imem_req); end
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rf_no_stale got=%b exp=0", if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rf_first_fetch got=%b/%h exp=1/00000000", imem_req, imem_addr); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL rf_first_out got=%b/%h exp=1/00000000", if_valid, if_pc); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_delayed_ack();
    test_stall_full();
    test_flush_drain();
    test_flush_ack();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
